// File: rtl/data_ram.sv
// data_ram: word-organised data memory for the MEM stage RAM port.
//   Synchronous 32-bit RAM with per-byte-lane writes, registered read data,
//   optional wait states and range checking against a base byte address.
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   ram_en           access request; accepted on an edge where ram_ready=1
//   ram_write_en[3:0] byte-lane write enables; all zero = read
//   ram_addr[31:0]   byte address, bits [1:0] ignored
//   ram_write_data   write data, lane i = bits [8i+7:8i]
//   ram_read_data    registered read data, holds until the next read completes
//   ram_ready        1 = idle and accepting, 0 = busy (requester stalls)
//   ram_addr_err     one-cycle pulse after an out-of-range access completes
module data_ram #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ram_en,
   input  logic [3:0]  ram_write_en,
   input  logic [31:0] ram_addr,
   input  logic [31:0] ram_write_data,
   output logic [31:0] ram_read_data,
   output logic        ram_ready,
   output logic        ram_addr_err
);

   localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W   = 4;
   localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic                    err_q, err_d;
   logic [31:0]             rd_q, rd_d;
   logic [31:0]             addr_q, addr_d;
   logic [3:0]              we_q, we_d;
   logic [31:0]             wd_q, wd_d;

   logic [31:0]             mem [DEPTH];

   logic [31:0]             op_addr_c;
   logic [3:0]              op_we_c;
   logic [31:0]             op_wd_c;
   logic [32:0]             diff_c;
   logic                    in_range_c;
   logic [ADDR_WIDTH-1:0]   idx_c;
   logic                    done_c;
   logic                    mem_wr_c;

   // Operand select: live inputs when there are no wait states, latched copy otherwise
   always_comb begin
      op_addr_c = NO_WAIT ? ram_addr       : addr_q;
      op_we_c   = NO_WAIT ? ram_write_en   : we_q;
      op_wd_c   = NO_WAIT ? ram_write_data : wd_q;
      // 33-bit difference: bit 32 set means the address is below the base
      diff_c     = {1'b0, op_addr_c} - {1'b0, BASE_ADDR};
      in_range_c = ~diff_c[32] & (diff_c[31:ADDR_WIDTH+2] == '0);
      idx_c      = diff_c[ADDR_WIDTH+1:2];
      done_c     = NO_WAIT ? (ram_en & ready_q)
                           : ((state_q == ST_BUSY) && (cnt_q == CNT_W'(1)));
      mem_wr_c   = rst_n & done_c & in_range_c & (op_we_c != 4'b0000);
   end

   // Next-state, wait counter, request latch and output computation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      err_d   = 1'b0;
      rd_d    = rd_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wd_d    = wd_q;

      if (NO_WAIT) begin
         state_d = ST_IDLE;
         ready_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ram_en && ready_q) begin
                  state_d = ST_BUSY;
                  cnt_d   = CNT_W'(WAIT_CYCLES);
                  ready_d = 1'b0;
                  addr_d  = ram_addr;
                  we_d    = ram_write_en;
                  wd_d    = ram_write_data;
               end
            end
            ST_BUSY: begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  ready_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               ready_d = 1'b1;
            end
         endcase
      end

      // Completion effects; a write completion leaves read data untouched
      if (done_c) begin
         if (!in_range_c) begin
            err_d = 1'b1;
            if (op_we_c == 4'b0000) rd_d = 32'h0;
         end else if (op_we_c == 4'b0000) begin
            rd_d = mem[idx_c];
         end
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         err_q   <= 1'b0;
         rd_q    <= 32'h0;
         addr_q  <= 32'h0;
         we_q    <= 4'h0;
         wd_q    <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wd_q    <= wd_d;
      end
   end

   // Storage array, not cleared by reset; byte lanes written independently
   always_ff @(posedge clk) begin
      if (mem_wr_c) begin
         for (int i = 0; i < 4; i++) begin
            if (op_we_c[i]) mem[idx_c][8*i +: 8] <= op_wd_c[8*i +: 8];
         end
      end
   end

   assign ram_read_data = rd_q;
   assign ram_ready     = ready_q;
   assign ram_addr_err  = err_q;

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed bench for data_ram with a timestamp-based reference model.
//   Instance 0: WAIT=0, BASE=0;  instance 1: WAIT=3, BASE=0;
//   instance 2: WAIT=0, BASE=0x1000, ADDR_WIDTH=4.
module tb_data_ram;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en   [3];
   logic [3:0]  we   [3];
   logic [31:0] addr [3];
   logic [31:0] wd   [3];
   logic [31:0] rd   [3];
   logic        rdy  [3];
   logic        err  [3];

   int n_vec = 0;
   int n_bad = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   data_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst_n(rst_n), .ram_en(en[0]), .ram_write_en(we[0]),
      .ram_addr(addr[0]), .ram_write_data(wd[0]), .ram_read_data(rd[0]),
      .ram_ready(rdy[0]), .ram_addr_err(err[0]));

   data_ram #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst_n(rst_n), .ram_en(en[1]), .ram_write_en(we[1]),
      .ram_addr(addr[1]), .ram_write_data(wd[1]), .ram_read_data(rd[1]),
      .ram_ready(rdy[1]), .ram_addr_err(err[1]));

   data_ram #(.ADDR_WIDTH(4), .BASE_ADDR(32'h1000), .WAIT_CYCLES(0)) u_rng (
      .clk(clk), .rst_n(rst_n), .ram_en(en[2]), .ram_write_en(we[2]),
      .ram_addr(addr[2]), .ram_write_data(wd[2]), .ram_read_data(rd[2]),
      .ram_ready(rdy[2]), .ram_addr_err(err[2]));

   function automatic int unsigned w_of(int i);
      return (i == 1) ? 3 : 0;
   endfunction
   function automatic longint base_of(int i);
      return (i == 2) ? 64'h1000 : 64'h0;
   endfunction
   function automatic int unsigned aw_of(int i);
      return (i == 2) ? 4 : 10;
   endfunction

   // ---------------- reference model ----------------
   int unsigned cyc = 0;
   bit          busy    [3];
   int unsigned due     [3];
   logic [31:0] p_a     [3];
   logic [31:0] p_d     [3];
   logic [3:0]  p_w     [3];
   logic [31:0] x_rd    [3];
   bit          x_known [3];
   bit          x_rdy   [3];
   bit          x_err   [3];
   logic [31:0] mem_m   [int unsigned];

   task automatic complete(int i, logic [31:0] a, logic [3:0] w, logic [31:0] d);
      longint      off;
      longint      span;
      bit          inr;
      int unsigned key;
      logic [31:0] word;
      off  = longint'(a) - base_of(i);
      span = longint'(4) << aw_of(i);
      inr  = (off >= 0) && (off < span);
      key  = inr ? (32'(i) * 32'd65536 + 32'(off / 4)) : 32'd0;
      x_err[i] = !inr;
      if (w != 4'b0000) begin
         if (inr) begin
            word = mem_m.exists(key) ? mem_m[key] : 32'h0;
            for (int b = 0; b < 4; b++) if (w[b]) word[8*b +: 8] = d[8*b +: 8];
            mem_m[key] = word;
         end
      end else if (!inr) begin
         x_rd[i] = 32'h0;  x_known[i] = 1'b1;
      end else if (mem_m.exists(key)) begin
         x_rd[i] = mem_m[key];  x_known[i] = 1'b1;
      end else begin
         x_known[i] = 1'b0;
      end
   endtask

   task automatic step(int i);
      x_err[i] = 1'b0;
      if (busy[i]) begin
         if (cyc == due[i]) begin
            complete(i, p_a[i], p_w[i], p_d[i]);
            busy[i] = 1'b0;
         end
      end else if (en[i]) begin
         if (w_of(i) == 0) complete(i, addr[i], we[i], wd[i]);
         else begin
            busy[i] = 1'b1;
            due[i]  = cyc + w_of(i);
            p_a[i]  = addr[i];  p_w[i] = we[i];  p_d[i] = wd[i];
         end
      end
      x_rdy[i] = !busy[i];
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            busy[i] = 1'b0;  x_rd[i] = 32'h0;  x_known[i] = 1'b1;
            x_rdy[i] = 1'b1; x_err[i] = 1'b0;
         end
      end else begin
         cyc = cyc + 1;
         for (int i = 0; i < 3; i++) step(i);
      end
   end

   // ---------------- checking ----------------
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("cmp_rdy%0d", i), 32'(rdy[i]), 32'(x_rdy[i]));
            chk($sformatf("cmp_err%0d", i), 32'(err[i]), 32'(x_err[i]));
            if (x_known[i]) chk($sformatf("cmp_rd%0d", i), rd[i], x_rd[i]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_in(int i, logic e, logic [3:0] w, logic [31:0] a, logic [31:0] d);
      en[i] = e;  we[i] = w;  addr[i] = a;  wd[i] = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] prev;
   logic [31:0] d6;

   initial begin
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) set_in(i, 1'b0, 4'h0, 32'h0, 32'h0);
      #2 rst_n = 1'b0;
      #1 started = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_rd", rd[i], 32'h0);
         chk("rst_rdy", 32'(rdy[i]), 32'd1);
         chk("rst_err", 32'(err[i]), 32'd0);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Full write then read, no wait states
      set_in(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF); tick();
      set_in(0, 1'b1, 4'h0, 32'h10, 32'h0);        tick();
      chk("t1_rd", rd[0], 32'hDEADBEEF);
      chk("t1_rdy", 32'(rdy[0]), 32'd1);
      chk("t1_model", x_rd[0], 32'hDEADBEEF);

      // Byte-lane merges
      set_in(0, 1'b1, 4'b0001, 32'h10, 32'h000000AA); tick();
      chk("t2_hold", rd[0], 32'hDEADBEEF);
      set_in(0, 1'b1, 4'b1000, 32'h10, 32'h55000000); tick();
      set_in(0, 1'b1, 4'b0000, 32'h10, 32'h0);        tick();
      chk("t2_rd", rd[0], 32'h55ADBEAA);
      chk("t2_model", x_rd[0], 32'h55ADBEAA);

      // Back-to-back alternating write/read
      prev = 32'h55ADBEAA;
      for (int k = 0; k < 4; k++) begin
         d6 = 32'hA5A50000 + 32'(k) * 32'h1111;
         set_in(0, 1'b1, 4'hF, 32'h100 + 32'(4 * k), d6); tick();
         chk("t6_hold", rd[0], prev);
         set_in(0, 1'b1, 4'h0, 32'h100 + 32'(4 * k), 32'h0); tick();
         chk("t6_rd", rd[0], d6);
         prev = d6;
      end
      set_in(0, 1'b0, 4'h0, 32'h0, 32'h0); tick();
      chk("t6_idle_hold", rd[0], prev);

      // Range checking, base 0x1000, 16 words
      set_in(2, 1'b1, 4'hF, 32'h1000, 32'h24681357); tick();
      chk("t4_err_ok", 32'(err[2]), 32'd0);
      set_in(2, 1'b1, 4'hF, 32'h103C, 32'h13579BDF); tick();
      set_in(2, 1'b1, 4'hF, 32'h1040, 32'hFFFFFFFF); tick();
      chk("t4_err_wr", 32'(err[2]), 32'd1);
      set_in(2, 1'b1, 4'h0, 32'h103C, 32'h0); tick();
      chk("t4_err_clr", 32'(err[2]), 32'd0);
      chk("t4_rd_top", rd[2], 32'h13579BDF);
      set_in(2, 1'b1, 4'h0, 32'h1000, 32'h0); tick();
      chk("t4_no_alias", rd[2], 32'h24681357);
      set_in(2, 1'b1, 4'h0, 32'h0FFC, 32'h0); tick();
      chk("t4_rd_low", rd[2], 32'h0);
      chk("t4_err_rd", 32'(err[2]), 32'd1);
      set_in(2, 1'b0, 4'h0, 32'h0, 32'h0); tick();
      chk("t4_pulse_end", 32'(err[2]), 32'd0);

      // Three wait states: write then held read
      set_in(1, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D); tick();
      for (int c = 0; c < 3; c++) begin
         chk("t3_wr_busy", 32'(rdy[1]), 32'd0);
         tick();
      end
      chk("t3_wr_done", 32'(rdy[1]), 32'd1);
      chk("t3_wr_rd_hold", rd[1], 32'h0);
      set_in(1, 1'b1, 4'h0, 32'h40, 32'h0); tick();
      for (int c = 0; c < 3; c++) begin
         chk("t3_rd_busy", 32'(rdy[1]), 32'd0);
         chk("t3_rd_old", rd[1], 32'h0);
         tick();
      end
      chk("t3_rd_done", 32'(rdy[1]), 32'd1);
      chk("t3_rd_data", rd[1], 32'hCAFEF00D);
      set_in(1, 1'b0, 4'h0, 32'h0, 32'h0); tick();
      chk("t3_no_extra", 32'(rdy[1]), 32'd1);

      // Reset during a pending write drops it
      set_in(1, 1'b1, 4'hF, 32'h20, 32'h11112222); tick();
      repeat (3) tick();
      set_in(1, 1'b1, 4'hF, 32'h20, 32'h12345678); tick();
      tick();
      #2 rst_n = 1'b0;
      set_in(1, 1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      chk("t5_rst_rd", rd[1], 32'h0);
      chk("t5_rst_rdy", 32'(rdy[1]), 32'd1);
      chk("t5_rst_err", 32'(err[1]), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      set_in(1, 1'b1, 4'h0, 32'h20, 32'h0); tick();
      repeat (3) tick();
      chk("t5_old_value", rd[1], 32'h11112222);
      chk("t5_model", x_rd[1], 32'h11112222);
      set_in(1, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
